// File: rtl/operand_fetch_pkg.sv
// Shared MIPS field layout, opcode constants and decode helpers for the issue stage and alu.
package operand_fetch_pkg;

  localparam int NREGS = 32;
  localparam int XLEN  = 32;
  localparam int AW    = $clog2(NREGS);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;

  // alu picks its operands by these fixed register fields.
  localparam logic [4:0] SEL_A = 5'd0;
  localparam logic [4:0] SEL_B = 5'd1;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] reg_a;
    logic [XLEN-1:0] reg_b;
  } issue_t;

  function automatic logic [AW-1:0] dest_of(input logic [XLEN-1:0] instr);
    logic [AW-1:0] d;
    d = '0;
    case (instr[OP_HI:OP_LO])
      OP_RTYPE: d = instr[RD_HI:RD_LO];
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI,
      OP_SLTI, OP_SLTIU, OP_LW: d = instr[RT_HI:RT_LO];
      default: d = '0;
    endcase
    return d;
  endfunction

  function automatic logic [XLEN-1:0] alu_view(input logic [XLEN-1:0] instr);
    return {instr[OP_HI:OP_LO], SEL_A, SEL_B, instr[RD_HI:0]};
  endfunction

endpackage

// File: rtl/operand_fetch_reg_file.sv
// Architectural register file: two combinational read ports with write-through bypass, one write port.
module operand_fetch_reg_file
  import operand_fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rd_addr_a,
  output logic [XLEN-1:0] rd_data_a,
  input  logic [AW-1:0]   rd_addr_b,
  output logic [XLEN-1:0] rd_data_b,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data
);

  logic [XLEN-1:0] mem [NREGS];

  // NOTE: the whole array is reset because the architecture defines every GPR as 0 after reset;
  // a plain RAM macro would not do that, so this stays flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (wr_en && wr_addr != '0) begin
      // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
      mem[wr_addr] <= wr_data;
    end
  end

  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] idx,
                                                input logic [XLEN-1:0] stored);
    if (idx == '0)                    return '0;
    else if (wr_en && wr_addr == idx) return wr_data;
    else                              return stored;
  endfunction

  assign rd_data_a = read_port(rd_addr_a, mem[rd_addr_a]);
  assign rd_data_b = read_port(rd_addr_b, mem[rd_addr_b]);

endmodule

// File: rtl/operand_fetch.sv
// Issue stage: reads rs/rt, tracks pending writes, stalls on RAW hazards, registers alu operands.
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_instr,
  output logic [XLEN-1:0] alu_reg_a,
  output logic [XLEN-1:0] alu_reg_b
);

  logic [AW-1:0]    rs, rt, dest;
  logic [XLEN-1:0]  rd_a, rd_b;
  logic [NREGS-1:0] pend, pend_next, wb_clr, pend_live;
  logic             hazard, accept;
  issue_t           out_q;

  assign rs   = in_instr[RS_HI:RS_LO];
  assign rt   = in_instr[RT_HI:RT_LO];
  assign dest = dest_of(in_instr);

  operand_fetch_reg_file u_reg_file (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr_a (rs),
    .rd_data_a (rd_a),
    .rd_addr_b (rt),
    .rd_data_b (rd_b),
    .wr_en     (wb_en),
    .wr_addr   (wb_addr),
    .wr_data   (wb_data)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wb_clr = '0;
    if (wb_en && wb_addr != '0) wb_clr[wb_addr] = 1'b1;
    pend_live = pend & ~wb_clr;
    hazard    = (pend_live[rs] && rs != '0) || (pend_live[rt] && rt != '0);
    in_ready  = !hazard && (!out_valid || out_ready);
    accept    = in_valid && in_ready;
    // A new writer claims the register even if an older write retires this cycle.
    pend_next = pend_live;
    if (accept && dest != '0) pend_next[dest] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= '0;
      out_valid <= 1'b0;
      out_q     <= '0;
    end else begin
      pend <= pend_next;
      if (accept) begin
        out_valid   <= 1'b1;
        out_q.instr <= alu_view(in_instr);
        out_q.reg_a <= rd_a;
        out_q.reg_b <= rd_b;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign alu_instr = out_q.instr;
  assign alu_reg_a = out_q.reg_a;
  assign alu_reg_b = out_q.reg_b;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: operand table plus hazard, stall, scoreboard and reset sequences.
module tb_operand_fetch;
  import operand_fetch_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [XLEN-1:0] in_instr = '0;
  logic            wb_en = 1'b0;
  logic [AW-1:0]   wb_addr = '0;
  logic [XLEN-1:0] wb_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] alu_instr, alu_reg_a, alu_reg_b;

  int n_checks = 0;
  int n_fail   = 0;

  operand_fetch dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_instr (alu_instr),
    .alu_reg_a (alu_reg_a),
    .alu_reg_b (alu_reg_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [31:0] exp_alu;
  } vec_t;

  vec_t vecs [8];

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] funct);
    return {6'b000000, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    wb_en     = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wb(input logic [4:0] addr, input logic [31:0] data);
    wb_en   = 1'b1;
    wb_addr = addr;
    wb_data = data;
    step();
    wb_en = 1'b0;
  endtask

  initial begin
    logic [31:0] held;

    do_reset();
    #1;
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset alu_instr", alu_instr, 32'd0);
    check("reset alu_reg_a", alu_reg_a, 32'd0);
    check("reset alu_reg_b", alu_reg_b, 32'd0);
    check("reset in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    // ---------------- table of single issues, back to back ----------------
    wb(5'd1, 32'd3);
    wb(5'd2, 32'd1);
    wb(5'd3, 32'h0000_0100);
    wb(5'd4, 32'hdead_beef);
    wb(5'd5, 32'd7);
    wb(5'd6, 32'h8000_0000);
    wb(5'd7, 32'h1234_5678);

    vecs[0] = '{rtype(5'd1, 5'd2, 5'd10, 6'h20), 32'd3, 32'd1, 32'h0001_5020};
    vecs[1] = '{itype(OP_ADDI, 5'd3, 5'd11, 16'h1234), 32'h100, 32'd0, 32'h2001_1234};
    vecs[2] = '{itype(OP_SW, 5'd4, 5'd5, 16'h0008), 32'hdead_beef, 32'd7, 32'hac01_0008};
    vecs[3] = '{itype(OP_BEQ, 5'd0, 5'd6, 16'hfffe), 32'd0, 32'h8000_0000, 32'h1001_fffe};
    vecs[4] = '{itype(OP_LW, 5'd7, 5'd12, 16'hfffc), 32'h1234_5678, 32'd0, 32'h8c01_fffc};
    vecs[5] = '{rtype(5'd7, 5'd4, 5'd13, 6'h25), 32'h1234_5678, 32'hdead_beef, 32'h0001_6825};
    vecs[6] = '{itype(6'b111111, 5'd2, 5'd3, 16'h00ff), 32'd1, 32'h100, 32'hfc01_00ff};
    vecs[7] = '{itype(OP_ORI, 5'd5, 5'd0, 16'h0f0f), 32'd7, 32'd0, 32'h3401_0f0f};

    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      #1;
      check($sformatf("vec%0d in_ready", i), {31'd0, in_ready}, 32'd1);
      step();
      check($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("vec%0d reg_a", i), alu_reg_a, vecs[i].exp_a);
      check($sformatf("vec%0d reg_b", i), alu_reg_b, vecs[i].exp_b);
      check($sformatf("vec%0d alu_instr", i), alu_instr, vecs[i].exp_alu);
      if (i == 0) check("add rs/rt fields", {22'd0, alu_instr[25:16]}, 32'h0000_0001);
    end
    in_valid = 1'b0;
    step();
    check("drain out_valid", {31'd0, out_valid}, 32'd0);

    // Scoreboard after the table: r10, r12 pending; sw/beq/ori-to-r0 left r5, r6 free.
    in_instr = rtype(5'd10, 5'd0, 5'd20, 6'h20);
    #1 check("pend r10 stalls", {31'd0, in_ready}, 32'd0);
    in_instr = rtype(5'd0, 5'd12, 5'd20, 6'h20);
    #1 check("pend r12 (lw) stalls", {31'd0, in_ready}, 32'd0);
    in_instr = rtype(5'd5, 5'd6, 5'd20, 6'h20);
    #1 check("sw/beq set no bits", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    // ---------------- RAW stall released by writeback with bypass ----------------
    do_reset();
    wb(5'd1, 32'd3);
    in_valid = 1'b1;
    in_instr = rtype(5'd1, 5'd1, 5'd3, 6'h20);
    step();
    in_instr = rtype(5'd3, 5'd0, 5'd4, 6'h20);
    #1 check("raw stall c0", {31'd0, in_ready}, 32'd0);
    step();
    check("raw stall out_valid drops", {31'd0, out_valid}, 32'd0);
    check("raw stall c1", {31'd0, in_ready}, 32'd0);
    step();
    check("raw stall c2", {31'd0, in_ready}, 32'd0);
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h55;
    #1 check("wb cycle in_ready", {31'd0, in_ready}, 32'd1);
    step();
    wb_en = 1'b0;
    check("bypass out_valid", {31'd0, out_valid}, 32'd1);
    check("bypass reg_a", alu_reg_a, 32'h55);

    // ---------------- output back-pressure ----------------
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = rtype(5'd1, 5'd0, 5'd5, 6'h20);
    step();
    check("bp first out_valid", {31'd0, out_valid}, 32'd1);
    check("bp first reg_a", alu_reg_a, 32'd3);
    held = alu_instr;
    in_instr = rtype(5'd3, 5'd1, 5'd6, 6'h22);
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("bp c%0d in_ready", c), {31'd0, in_ready}, 32'd0);
      step();
      check($sformatf("bp c%0d out_valid", c), {31'd0, out_valid}, 32'd1);
      check($sformatf("bp c%0d reg_a", c), alu_reg_a, 32'd3);
      check($sformatf("bp c%0d alu_instr", c), alu_instr, held);
    end
    out_ready = 1'b1;
    #1 check("bp release in_ready", {31'd0, in_ready}, 32'd1);
    step();
    check("bp next reg_a", alu_reg_a, 32'h55);
    check("bp next reg_b", alu_reg_b, 32'd3);
    check("bp next alu_instr", alu_instr, 32'h0001_3022);
    in_valid = 1'b0;
    step();

    // ---------------- set wins over same-cycle clear ----------------
    do_reset();
    in_valid = 1'b1;
    in_instr = itype(OP_ADDI, 5'd0, 5'd5, 16'd1);
    step();
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'd9;
    #1 check("set/clr in_ready", {31'd0, in_ready}, 32'd1);
    step();
    wb_en = 1'b0;
    check("set/clr b bypass", alu_reg_b, 32'd9);
    in_instr = rtype(5'd5, 5'd0, 5'd7, 6'h20);
    #1 check("pend5 held c0", {31'd0, in_ready}, 32'd0);
    step();
    check("pend5 held c1", {31'd0, in_ready}, 32'd0);
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h21;
    #1 check("second wb frees r5", {31'd0, in_ready}, 32'd1);
    step();
    wb_en = 1'b0;
    check("r5 consumer reg_a", alu_reg_a, 32'h21);

    // ---------------- r0 never tracked, never written ----------------
    do_reset();
    in_valid = 1'b1;
    in_instr = itype(OP_SW, 5'd0, 5'd0, 16'd4);
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hffff_ffff;
    #1 check("r0 sw in_ready", {31'd0, in_ready}, 32'd1);
    step();
    wb_en = 1'b0;
    check("r0 bypass ignored a", alu_reg_a, 32'd0);
    check("r0 bypass ignored b", alu_reg_b, 32'd0);
    in_instr = itype(OP_BEQ, 5'd0, 5'd0, 16'd2);
    #1 check("r0 beq in_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_instr = rtype(5'd0, 5'd0, 5'd8, 6'h20);
    #1 check("r0 add in_ready", {31'd0, in_ready}, 32'd1);
    step();
    check("r0 stays zero", alu_reg_a, 32'd0);
    in_valid = 1'b0;
    step();

    // ---------------- reset during a hazard stall ----------------
    do_reset();
    wb(5'd1, 32'd3);
    in_valid = 1'b1;
    in_instr = rtype(5'd1, 5'd1, 5'd3, 6'h20);
    step();
    out_ready = 1'b0;
    in_instr  = rtype(5'd3, 5'd0, 5'd4, 6'h20);
    #1 check("pre-reset stalled", {31'd0, in_ready}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("mid-reset out_valid", {31'd0, out_valid}, 32'd0);
    check("mid-reset pend cleared", {31'd0, in_ready}, 32'd1);
    check("mid-reset reg_a", alu_reg_a, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("post-reset in_ready", {31'd0, in_ready}, 32'd1);
    step();
    check("post-reset out_valid", {31'd0, out_valid}, 32'd1);
    check("post-reset reg_a (r3 cleared)", alu_reg_a, 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
